// File: rtl/call_stack_sequencer.sv
// call_stack_sequencer: program sequencer with a hardware return-address stack.
// pm_addr is the combinational next fetch address; pc, sp and the sticky error
// flags are registered. Program memory samples pm_addr on the falling edge.
module call_stack_sequencer #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned STACK_DEPTH = 4,
   parameter int unsigned RESET_ADDR  = 0,
   parameter int unsigned SP_W        = $clog2(STACK_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sync_reset,
   input  logic              hold,
   input  logic              jmp,
   input  logic              jmp_nz,
   input  logic              dont_jmp,
   input  logic              call,
   input  logic              ret,
   input  logic [ADDR_W-1:0] jmp_addr,
   output logic [ADDR_W-1:0] pm_addr,
   output logic [ADDR_W-1:0] pc,
   output logic [SP_W-1:0]   sp,
   output logic              stack_full,
   output logic              stack_empty,
   output logic              overflow,
   output logic              underflow
);

   // Entry index width; a single-entry stack still needs a one-bit index.
   localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int unsigned SLOTS = 1 << IDX_W;
   localparam logic [ADDR_W-1:0] RESET_V = ADDR_W'(RESET_ADDR);
   localparam logic [SP_W-1:0]   DEPTH_V = SP_W'(STACK_DEPTH);

   logic              started_q, started_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [SP_W-1:0]   sp_q, sp_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;

   logic [ADDR_W-1:0] stack_q [0:SLOTS-1];
   logic [ADDR_W-1:0] pc_inc_s;
   logic [IDX_W-1:0]  top_idx_s;
   logic [IDX_W-1:0]  push_idx_s;
   logic              push_s;

   // Sequential-address and stack-index helpers; pc+1 wraps modulo 2^ADDR_W.
   always_comb begin
      pc_inc_s   = pc_q + 1'b1;
      top_idx_s  = IDX_W'(sp_q - 1'b1);
      push_idx_s = IDX_W'(sp_q);
   end

   // Next-address priority selection together with the stack/flag effects it gates.
   always_comb begin
      pc_d        = pc_inc_s;
      sp_d        = sp_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      push_s      = 1'b0;
      started_d   = 1'b1;
      if (!started_q || sync_reset) begin
         // Not yet started or restarting: fetch from the reset vector, clear stack state.
         pc_d        = RESET_V;
         sp_d        = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else if (hold) begin
         pc_d = pc_q;
      end else if (ret) begin
         // ret dominates a simultaneous call; an empty stack falls through to pc+1.
         if (sp_q != '0) begin
            pc_d = stack_q[top_idx_s];
            sp_d = sp_q - 1'b1;
         end else begin
            pc_d        = pc_inc_s;
            underflow_d = 1'b1;
         end
      end else if (call) begin
         // The jump is taken even when the push is refused on a full stack.
         pc_d = jmp_addr;
         if (sp_q < DEPTH_V) begin
            push_s = 1'b1;
            sp_d   = sp_q + 1'b1;
         end else begin
            overflow_d = 1'b1;
         end
      end else if (jmp) begin
         pc_d = jmp_addr;
      end else if (jmp_nz && !dont_jmp) begin
         pc_d = jmp_addr;
      end else begin
         pc_d = pc_inc_s;
      end
   end

   // Control state: pc follows pm_addr every edge, async reset clears everything.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         started_q   <= 1'b0;
         pc_q        <= RESET_V;
         sp_q        <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         started_q   <= started_d;
         pc_q        <= pc_d;
         sp_q        <= sp_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Return-address storage; contents are meaningless above sp, so no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         stack_q[push_idx_s] <= pc_inc_s;
      end
   end

   // Output mapping; status bits decode registered sp only.
   always_comb begin
      pm_addr     = pc_d;
      pc          = pc_q;
      sp          = sp_q;
      stack_full  = (sp_q == DEPTH_V);
      stack_empty = (sp_q == '0);
      overflow    = overflow_q;
      underflow   = underflow_q;
   end

endmodule

// File: tb/tb_call_stack_sequencer.sv
// tb_call_stack_sequencer: directed vector table, async-reset corner sequence and
// randomized stimulus, all compared against a queue-based reference model.
module tb_call_stack_sequencer;

   typedef struct packed {
      logic       sr, hold, jmp, jnz, dj, call, ret;
      logic [7:0] ja;
   } in_t;

   typedef struct {
      in_t        i;
      logic [7:0] pm;
      logic [7:0] pc;
      logic [2:0] sp;
      logic       ov;
      logic       un;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset, sync_reset, hold, jmp, jmp_nz, dont_jmp, call, ret;
   logic [7:0] jmp_addr, pm_addr, pc;
   logic [2:0] sp;
   logic       stack_full, stack_empty, overflow, underflow;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state: a queue stands in for the return stack.
   logic [7:0] stk_m[$];
   logic [7:0] pc_m;
   bit         started_m, ov_m, un_m;

   vec_t tbl[$];

   call_stack_sequencer dut (
      .clk(clk), .reset(reset), .sync_reset(sync_reset), .hold(hold),
      .jmp(jmp), .jmp_nz(jmp_nz), .dont_jmp(dont_jmp), .call(call), .ret(ret),
      .jmp_addr(jmp_addr), .pm_addr(pm_addr), .pc(pc), .sp(sp),
      .stack_full(stack_full), .stack_empty(stack_empty),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic in_t ci(input bit sr, input bit hd, input bit jp, input bit jn,
                              input bit dj, input bit cl, input bit rt, input logic [7:0] a);
      in_t v;
      v.sr = sr; v.hold = hd; v.jmp = jp; v.jnz = jn; v.dj = dj;
      v.call = cl; v.ret = rt; v.ja = a;
      return v;
   endfunction

   task automatic add(input in_t i, input logic [7:0] pm, input logic [7:0] pcv,
                      input logic [2:0] spv, input logic ov, input logic un);
      vec_t e;
      e.i = i; e.pm = pm; e.pc = pcv; e.sp = spv; e.ov = ov; e.un = un;
      tbl.push_back(e);
   endtask

   function automatic logic [7:0] model_pm(input in_t v);
      if (!started_m || v.sr) return 8'h00;
      if (v.hold) return pc_m;
      if (v.ret) return (stk_m.size() > 0) ? stk_m[$] : pc_m + 8'd1;
      if (v.call || v.jmp || (v.jnz && !v.dj)) return v.ja;
      return pc_m + 8'd1;
   endfunction

   task automatic model_update(input in_t v, input logic [7:0] pm);
      logic [7:0] nx;
      nx = pc_m + 8'd1;
      if (!started_m || v.sr) begin
         stk_m.delete();
         ov_m = 1'b0;
         un_m = 1'b0;
      end else if (!v.hold) begin
         if (v.ret) begin
            if (stk_m.size() > 0) void'(stk_m.pop_back());
            else un_m = 1'b1;
         end else if (v.call) begin
            if (stk_m.size() < 4) stk_m.push_back(nx);
            else ov_m = 1'b1;
         end
      end
      pc_m      = pm;
      started_m = 1'b1;
   endtask

   task automatic model_reset();
      stk_m.delete();
      pc_m = 8'h00; started_m = 1'b0; ov_m = 1'b0; un_m = 1'b0;
   endtask

   // One cycle: drive at negedge, check pm_addr before the edge, state after it.
   task automatic step(input in_t v, input bit use_tbl, input vec_t e);
      logic [7:0] pm_exp;
      sync_reset = v.sr; hold = v.hold; jmp = v.jmp; jmp_nz = v.jnz;
      dont_jmp = v.dj; call = v.call; ret = v.ret; jmp_addr = v.ja;
      pm_exp = model_pm(v);
      #1;
      chk("pm_addr", 32'(pm_addr), 32'(pm_exp));
      if (use_tbl) chk("tbl_pm_addr", 32'(pm_addr), 32'(e.pm));
      @(posedge clk);
      model_update(v, pm_exp);
      @(negedge clk);
      chk("pc", 32'(pc), 32'(pc_m));
      chk("sp", 32'(sp), 32'(stk_m.size()));
      chk("stack_full", 32'(stack_full), 32'(stk_m.size() == 4));
      chk("stack_empty", 32'(stack_empty), 32'(stk_m.size() == 0));
      chk("overflow", 32'(overflow), 32'(ov_m));
      chk("underflow", 32'(underflow), 32'(un_m));
      if (use_tbl) begin
         chk("tbl_pc", 32'(pc), 32'(e.pc));
         chk("tbl_sp", 32'(sp), 32'(e.sp));
         chk("tbl_overflow", 32'(overflow), 32'(e.ov));
         chk("tbl_underflow", 32'(underflow), 32'(e.un));
      end
   endtask

   initial begin
      vec_t dummy;
      in_t  v;
      dummy = '{default: '0};

      //   inputs:  sr hd jp jn dj cl rt ja            pm     pc     sp  ov  un
      add(ci(0,0,0,0,0,0,0,8'h00),          8'h00, 8'h00, 3'd0, 0, 0); // first edge after release
      add(ci(0,0,0,0,0,0,0,8'h00),          8'h01, 8'h01, 3'd0, 0, 0);
      add(ci(0,0,0,0,0,0,0,8'h00),          8'h02, 8'h02, 3'd0, 0, 0);
      add(ci(0,0,0,0,0,0,0,8'h00),          8'h03, 8'h03, 3'd0, 0, 0);
      add(ci(0,0,1,0,0,0,0,8'h10),          8'h10, 8'h10, 3'd0, 0, 0);
      add(ci(0,0,0,0,0,1,0,8'h40),          8'h40, 8'h40, 3'd1, 0, 0); // pushes 0x11
      add(ci(0,0,0,0,0,0,0,8'h00),          8'h41, 8'h41, 3'd1, 0, 0);
      add(ci(0,0,0,0,0,0,0,8'h00),          8'h42, 8'h42, 3'd1, 0, 0);
      add(ci(0,0,0,0,0,0,0,8'h00),          8'h43, 8'h43, 3'd1, 0, 0);
      add(ci(0,0,0,0,0,0,1,8'h00),          8'h11, 8'h11, 3'd0, 0, 0);
      add(ci(0,0,0,0,0,0,1,8'h00),          8'h12, 8'h12, 3'd0, 0, 1); // underflow
      add(ci(1,0,0,0,0,0,0,8'h00),          8'h00, 8'h00, 3'd0, 0, 0);
      add(ci(0,0,1,0,0,0,0,8'h1F),          8'h1F, 8'h1F, 3'd0, 0, 0);
      add(ci(0,0,0,1,1,0,0,8'h80),          8'h20, 8'h20, 3'd0, 0, 0); // not taken
      add(ci(0,0,0,1,0,0,0,8'h80),          8'h80, 8'h80, 3'd0, 0, 0); // taken
      add(ci(0,0,1,0,0,0,0,8'hFF),          8'hFF, 8'hFF, 3'd0, 0, 0);
      add(ci(0,0,0,0,0,0,0,8'h00),          8'h00, 8'h00, 3'd0, 0, 0); // wrap
      add(ci(0,0,0,0,0,1,0,8'h30),          8'h30, 8'h30, 3'd1, 0, 0); // pushes 0x01
      add(ci(0,1,0,0,0,1,0,8'h55),          8'h30, 8'h30, 3'd1, 0, 0); // hold beats call
      add(ci(0,0,0,0,0,1,1,8'h66),          8'h01, 8'h01, 3'd0, 0, 0); // ret beats call
      add(ci(0,0,0,0,0,1,0,8'hA0),          8'hA0, 8'hA0, 3'd1, 0, 0); // pushes 0x02
      add(ci(0,0,0,0,0,1,0,8'hA1),          8'hA1, 8'hA1, 3'd2, 0, 0);
      add(ci(0,0,0,0,0,1,0,8'hA2),          8'hA2, 8'hA2, 3'd3, 0, 0);
      add(ci(0,0,0,0,0,1,0,8'hA3),          8'hA3, 8'hA3, 3'd4, 0, 0);
      add(ci(0,0,0,0,0,1,0,8'hA4),          8'hA4, 8'hA4, 3'd4, 1, 0); // overflow, jump kept
      add(ci(0,0,0,0,0,0,1,8'h00),          8'hA3, 8'hA3, 3'd3, 1, 0);
      add(ci(0,0,0,0,0,0,1,8'h00),          8'hA2, 8'hA2, 3'd2, 1, 0);
      add(ci(0,0,0,0,0,0,1,8'h00),          8'hA1, 8'hA1, 3'd1, 1, 0);
      add(ci(0,0,0,0,0,0,1,8'h00),          8'h02, 8'h02, 3'd0, 1, 0);
      add(ci(1,1,0,0,0,1,1,8'h77),          8'h00, 8'h00, 3'd0, 0, 0); // sync_reset wins

      reset = 1'b0; sync_reset = 1'b0; hold = 1'b0; jmp = 1'b0; jmp_nz = 1'b0;
      dont_jmp = 1'b0; call = 1'b0; ret = 1'b0; jmp_addr = 8'h00;
      model_reset();
      #1;
      chk("rst_pm_addr", 32'(pm_addr), 32'h00);
      chk("rst_pc", 32'(pc), 32'h00);
      chk("rst_sp", 32'(sp), 32'h0);
      chk("rst_stack_empty", 32'(stack_empty), 32'h1);
      chk("rst_flags", 32'({overflow, underflow}), 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      foreach (tbl[k]) step(tbl[k].i, 1'b1, tbl[k]);

      // Fill the stack, hold, then pulse async reset mid-cycle.
      for (int k = 0; k < 4; k++) step(ci(0,0,0,0,0,1,0,8'(8'h50 + 8'(k * 16))), 1'b0, dummy);
      step(ci(0,1,0,0,0,0,0,8'h00), 1'b0, dummy);
      hold = 1'b1;
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      chk("async_pc", 32'(pc), 32'h00);
      chk("async_sp", 32'(sp), 32'h0);
      chk("async_pm_addr", 32'(pm_addr), 32'h00);
      chk("async_flags", 32'({stack_full, overflow, underflow}), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 3; k++) step(ci(0,0,0,0,0,0,0,8'h00), 1'b0, dummy);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 600; n++) begin
         v.sr   = ($urandom_range(0, 49) == 0);
         v.hold = ($urandom_range(0, 7) == 0);
         v.jmp  = ($urandom_range(0, 7) == 0);
         v.jnz  = ($urandom_range(0, 5) == 0);
         v.dj   = $urandom_range(0, 1) == 1;
         v.call = ($urandom_range(0, 3) == 0);
         v.ret  = ($urandom_range(0, 4) == 0);
         v.ja   = 8'($urandom);
         step(v, 1'b0, dummy);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/call_stack_sequencer.md
Name: call_stack_sequencer

Overview:
- Parametrised successor to the micro's program sequencer.
- Generates the combinational program-memory fetch address `pm_addr` and the registered program counter `pc`.
- Supports a full-width jump target, conditional jump, and hold/stall.
- Adds a hardware return-address stack for call/return, with full/empty status and sticky overflow/underflow error flags.
- Sits between the instruction decoder (jmp/jmp_nz/call/ret/hold, target field), the computational unit (zero flag into `dont_jmp`) and program memory (clocked on ~clk, so `pm_addr` is combinational from registered state).

Parameters:
- ADDR_W, 8, width of `pm_addr`, `pc`, `jmp_addr` and stack entries.
- STACK_DEPTH, 4, number of return-address entries (≥1).
- RESET_ADDR, 0, first fetch address after reset or sync_reset.
- SP_W, $clog2(STACK_DEPTH+1), width of the stack-pointer output (derived; not for override).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- sync_reset  input  1  synchronous restart, active-high, registered upstream.
- hold  input  1  stall: refetch current pc.
- jmp  input  1  unconditional jump.
- jmp_nz  input  1  conditional jump, taken when dont_jmp=0.
- dont_jmp  input  1  zero flag from the computational unit.
- call  input  1  push return address (pc+1), jump to jmp_addr.
- ret  input  1  pop return address, jump to it.
- jmp_addr  input  ADDR_W  jump/call target.
- pm_addr  output  ADDR_W  combinational next fetch address.
- pc  output  ADDR_W  registered address of the instruction now in flight.
- sp  output  SP_W  stack occupancy, 0..STACK_DEPTH.
- stack_full  output  1  sp == STACK_DEPTH.
- stack_empty  output  1  sp == 0.
- overflow  output  1  sticky: call attempted while full.
- underflow  output  1  sticky: ret attempted while empty.

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_ADDR, sp=0, overflow=0, underflow=0, started=0.
  - pm_addr=RESET_ADDR while reset is low.
  - Stack RAM contents are don't-care.
- started flag:
  - While started=0, pm_addr=RESET_ADDR.
  - Set on the first rising edge after reset release, so the first edge loads pc=RESET_ADDR.
  - Without this flag, fetch would begin at RESET_ADDR+1.
- pm_addr selection, strict priority:
  1. !started or sync_reset → RESET_ADDR.
  2. hold → pc.
  3. ret → top-of-stack if sp>0, else pc+1.
  4. call → jmp_addr.
  5. jmp → jmp_addr.
  6. jmp_nz & !dont_jmp → jmp_addr.
  7. else → pc+1.
- pc update: pc <= pm_addr every rising edge (hold therefore keeps pc constant).
- pc+1 arithmetic: modulo 2^ADDR_W; all-ones wraps to 0, no flag.
- Stack operations take effect on the same edge that loads pc; effects are gated by the priority above (hold or sync_reset suppresses push/pop).
  - call, sp<STACK_DEPTH: write pc+1 (wrapped) to entry[sp]; sp+1.
  - call, full: no write, sp unchanged, overflow<=1; the jump is still taken.
  - ret, sp>0: sp-1; pm_addr = entry[sp-1] combinationally that cycle.
  - ret, sp==0: sp unchanged, underflow<=1, fall through to pc+1.
  - call and ret together: ret wins, call ignored, no push, no overflow check.
  - Zero-depth net effect: call immediately followed by ret returns to the instruction after the call.
- sync_reset: on the next edge, sp=0, overflow=0, underflow=0, pc=RESET_ADDR. It overrides hold, call and ret in the same cycle.
- Async reset mid-operation (e.g. during a hold or with a full stack): all state returns to reset values immediately.
- Status outputs: stack_full and stack_empty are decoded from registered sp (no combinational path from inputs). overflow and underflow are registered.

Test Plan:
- Reset release with no control inputs → pm_addr=0 for the first cycle; pc goes 0,1,2,3 on successive edges; stack_empty=1.
- ADDR_W=8, pc=0xFF, no control → pm_addr=0x00, next pc=0x00, no flags set.
- pc=0x10, call, jmp_addr=0x40 → pc=0x40, sp=1, entry0=0x11. Three cycles later, ret → pm_addr=0x11 that cycle, pc=0x11, sp=0.
- Five nested calls with STACK_DEPTH=4 → sp saturates at 4, stack_full=1, overflow=1 after the fifth call. The fifth call still jumps; overflow stays 1 through four rets until sync_reset clears it.
- ret with sp=0 at pc=0x20 → pc=0x21, underflow=1. Separately, ret+call together with sp=1 → pops, sp=0, no push.
- hold during a pending call (pc=0x30) → pc stays 0x30, sp unchanged. jmp_nz with dont_jmp=1 → pc+1; with dont_jmp=0 → jmp_addr. reset pulsed low mid-hold → pc=0, sp=0 asynchronously.
